// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one 32-bit CLA adder
// Carry registers are kept per requester so multiword add/sub can be chained.

module CarryLookAhead_Adder_32bit (
  input  logic [31:0] addend1_i,
  input  logic [31:0] addend2_i,
  input  logic        carry_in_i,
  output logic [31:0] sum_o,
  output logic        carry_out_o
);

  logic [31:0] g;
  logic [31:0] p;

  assign g = addend1_i & addend2_i;
  assign p = addend1_i ^ addend2_i;

  // 4-bit lookahead groups; group carries ripple between groups
  always_comb begin
    logic [32:0] c;
    c = '0;
    c[0] = carry_in_i;
    for (int grp = 0; grp < 8; grp++) begin
      c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
      c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                 | (p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+4] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                 | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
    end
    sum_o       = p ^ c[31:0];
    carry_out_o = c[32];
  end

endmodule

module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [NREQ-1:0]      req_chain,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic            capture;
  logic [31:0]     sel_a, sel_b;
  logic            sel_sub, sel_chain;

  logic [31:0]     a_q, b_q;
  logic            sub_q, chain_q;
  logic [IDW-1:0]  id_q;
  logic [NREQ-1:0] carry_q;

  logic [31:0]     rsp_sum_q;
  logic            rsp_cout_q, rsp_ovf_q;
  logic [IDW-1:0]  rsp_id_q;

  logic [31:0]     addend2;
  logic            carry_in;
  logic [31:0]     sum;
  logic            carry_out;

  // First valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_sub   = 1'b0;
    sel_chain = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
        sel_sub   = req_sub[i];
        sel_chain = req_chain[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready = NREQ'(1) << gnt_idx;
          capture   = 1'b1;
          ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d   = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  assign addend2  = sub_q ? ~b_q : b_q;
  assign carry_in = chain_q ? carry_q[id_q] : sub_q;

  CarryLookAhead_Adder_32bit u_cla (
    .addend1_i   (a_q),
    .addend2_i   (addend2),
    .carry_in_i  (carry_in),
    .sum_o       (sum),
    .carry_out_o (carry_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      carry_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      chain_q    <= 1'b0;
      id_q       <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (capture) begin
        a_q     <= sel_a;
        b_q     <= sel_b;
        sub_q   <= sel_sub;
        chain_q <= sel_chain;
        id_q    <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_sum_q     <= sum;
        rsp_cout_q    <= carry_out;
        rsp_ovf_q     <= (a_q[31] == addend2[31]) & (sum[31] != a_q[31]);
        rsp_id_q      <= id_q;
        carry_q[id_q] <= carry_out;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed scoreboard bench for adder_share_arbiter

module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic [NREQ-1:0]     req_chain;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_sum;
  logic                rsp_cout;
  logic                rsp_ovf;
  logic                busy;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  exp_t            sbq[$];
  logic [NREQ-1:0] mcarry;
  int              checks = 0;
  int              errors = 0;
  exp_t            held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic chain);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sub[id]        = sub;
    req_chain[id]      = chain;
    req_valid[id]      = 1'b1;
  endtask

  // Reference arithmetic: 33-bit add of A, possibly inverted B, and carry-in
  task automatic push_exp(input int id);
    logic [31:0] a, b, bb;
    logic        cin, ovf;
    logic [32:0] r;
    exp_t        e;
    a   = req_a[32*id +: 32];
    b   = req_b[32*id +: 32];
    bb  = req_sub[id] ? ~b : b;
    cin = req_chain[id] ? mcarry[id] : req_sub[id];
    r   = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
    if (req_sub[id]) ovf = (a[31] != b[31]) && (r[31] != a[31]);
    else             ovf = (a[31] == b[31]) && (r[31] != a[31]);
    e.id   = IDW'(id);
    e.sum  = r[31:0];
    e.cout = r[32];
    e.ovf  = ovf;
    mcarry[id] = r[32];
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input int id);
    int              n;
    logic [NREQ-1:0] onehot;
    n = 0;
    onehot = NREQ'(1) << id;
    #1;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", (n < 20), 1);
    chk("grant_onehot", req_ready, onehot);
  endtask

  task automatic check_fields(input exp_t e);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, e.id);
    chk("rsp_sum", rsp_sum, e.sum);
    chk("rsp_cout", rsp_cout, e.cout);
    chk("rsp_ovf", rsp_ovf, e.ovf);
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("sb_nonempty", (sbq.size() > 0), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_fields(e);
    end
  endtask

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic chain);
    set_req(id, a, b, sub, chain);
    wait_grant(id);
    push_exp(id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    @(negedge clk);
    check_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_chain = '0;
    mcarry    = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'(16 * i), 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    rst = 1'b0;

    // All requesters held valid from reset: rotation 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      wait_grant(k % NREQ);
      push_exp(k % NREQ);
      @(negedge clk);
      chk("fair_exec_valid", rsp_valid, 0);
      @(negedge clk);
      check_rsp();
    end
    req_valid = '0;

    do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    do_op(1, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
    do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    do_op(1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);

    do_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op(3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    do_op(2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    // Backpressure: response held five cycles while requester 3 waits
    set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_grant(1);
    push_exp(1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b0;
    @(negedge clk);
    held = sbq.pop_front();
    check_fields(held);
    set_req(3, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check_fields(held);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_grant", req_ready, 4'b1000);
    push_exp(3);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    check_rsp();

    // Reset while EXEC: carry and pointer cleared, operation dropped
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_grant(0);
    push_exp(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("midop_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    mcarry = '0;
    chk("midop_rsp_valid", rsp_valid, 0);
    chk("midop_busy_clr", busy, 0);
    chk("midop_rsp_sum", rsp_sum, 0);
    set_req(3, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0);
    set_req(0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    wait_grant(0);
    push_exp(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_rsp();
    do_op(3, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
